// File: rtl/cordic_pin_pkg.sv
// Shared types and constants for the CORDIC byte-serial pin host.
// Covers the sequencer states, pin bit positions and the command byte layout.
package cordic_pin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_GAP      = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_ACK      = 3'd4,
        ST_DROP     = 3'd5,
        ST_RESP     = 3'd6
    } state_e;

    localparam int WR_STROBE_BIT = 0;
    localparam int RD_ACK_BIT    = 1;
    localparam int BUSY_BIT      = 2;
    localparam int RES_VALID_BIT = 3;

    localparam logic [7:0] CMD_START = 8'h80;

    localparam int N_WR_BYTES = 3;
    localparam int N_RD_BYTES = 4;

    // Byte idx of the request frame: command+mode, then angle low, then angle high.
    function automatic logic [7:0] wr_byte(input logic [1:0] idx,
                                           input logic [1:0] mode,
                                           input logic [15:0] angle);
        logic [7:0] b;
        case (idx)
            2'd0:    b = CMD_START | {6'b000000, mode};
            2'd1:    b = angle[7:0];
            2'd2:    b = angle[15:8];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cordic_pin_timer.sv
// Clearable saturating cycle counter; expired is high once the count has reached
// TIMEOUT_CYCLES and stays high until cleared.
module cordic_pin_timer #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          expired_r;

    // Next count: clear wins, otherwise count up while enabled and below the limit.
    always_comb begin
        count_nxt_s = count_r;
        if (clr) begin
            count_nxt_s = {CW{1'b0}};
        end else if (en && (count_r != LIMIT)) begin
            count_nxt_s = count_r + CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register with the expired flag registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r   <= {CW{1'b0}};
            expired_r <= 1'b0;
        end else begin
            count_r   <= count_nxt_s;
            expired_r <= (count_nxt_s == LIMIT);
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/cordic_pin_host.sv
// Host-side sequencer: turns one parallel CORDIC request into three strobed pin
// writes, collects four acknowledged result bytes and returns one parallel response.
module cordic_pin_host
    import cordic_pin_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int STROBE_GAP     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_mode,
    input  logic [15:0] req_angle,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_x,
    output logic [15:0] rsp_y,
    output logic        rsp_err,
    output logic [7:0]  pin_ui,
    output logic [7:0]  pin_uio_to,
    input  logic [7:0]  pin_uo,
    input  logic [7:0]  pin_uio_from
);

    localparam int GW = (STROBE_GAP > 1) ? $clog2(STROBE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST   = GW'(STROBE_GAP - 1);
    localparam logic [1:0]    WCNT_LAST  = 2'(N_WR_BYTES - 1);
    localparam logic [1:0]    RCNT_LAST  = 2'(N_RD_BYTES - 1);

    state_e        state_r;
    logic [1:0]    mode_r;
    logic [15:0]   angle_r;
    logic [1:0]    wcnt_r;
    logic [1:0]    rcnt_r;
    logic [GW-1:0] gcnt_r;
    logic [7:0]    slot_r [N_RD_BYTES];
    logic [7:0]    pin_ui_r;
    logic          strobe_r;
    logic          ack_r;
    logic          rsp_valid_r;
    logic [15:0]   rsp_x_r;
    logic [15:0]   rsp_y_r;
    logic          rsp_err_r;

    logic          busy_s;
    logic          res_valid_s;
    logic          req_ready_s;
    logic          timer_clr_s;
    logic          timer_en_s;
    logic          expired_s;
    logic [7:0]    pin_uio_to_s;

    assign busy_s      = pin_uio_from[BUSY_BIT];
    assign res_valid_s = pin_uio_from[RES_VALID_BIT];
    assign req_ready_s = (state_r == ST_IDLE) && !busy_s;

    // Timer runs through the whole wait/ack/drop window of each byte and restarts per byte.
    always_comb begin
        timer_clr_s = 1'b0;
        timer_en_s  = 1'b0;
        case (state_r)
            ST_IDLE:     timer_clr_s = 1'b1;
            ST_WRITE:    timer_clr_s = 1'b1;
            ST_WAIT_RES: timer_en_s  = !res_valid_s;
            ST_ACK:      timer_en_s  = 1'b1;
            ST_DROP: begin
                timer_clr_s = !res_valid_s;
                timer_en_s  = res_valid_s;
            end
            default: begin
                timer_clr_s = 1'b0;
                timer_en_s  = 1'b0;
            end
        endcase
    end

    cordic_pin_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timer_clr_s),
        .en     (timer_en_s),
        .expired(expired_s)
    );

    // Sequencer FSM; pin and response outputs are set on the edge entering their state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            mode_r      <= 2'b00;
            angle_r     <= 16'h0000;
            wcnt_r      <= 2'b00;
            rcnt_r      <= 2'b00;
            gcnt_r      <= {GW{1'b0}};
            for (int i = 0; i < N_RD_BYTES; i++) begin
                slot_r[i] <= 8'h00;
            end
            pin_ui_r    <= 8'h00;
            strobe_r    <= 1'b0;
            ack_r       <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_x_r     <= 16'h0000;
            rsp_y_r     <= 16'h0000;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_s) begin
                        mode_r   <= req_mode;
                        angle_r  <= req_angle;
                        wcnt_r   <= 2'b00;
                        pin_ui_r <= wr_byte(2'd0, req_mode, req_angle);
                        strobe_r <= 1'b1;
                        state_r  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    strobe_r <= 1'b0;
                    gcnt_r   <= {GW{1'b0}};
                    if (wcnt_r == WCNT_LAST) begin
                        rcnt_r  <= 2'b00;
                        state_r <= ST_WAIT_RES;
                    end else begin
                        state_r <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gcnt_r == GAP_LAST) begin
                        wcnt_r   <= wcnt_r + 2'd1;
                        pin_ui_r <= wr_byte(wcnt_r + 2'd1, mode_r, angle_r);
                        strobe_r <= 1'b1;
                        state_r  <= ST_WRITE;
                    end else begin
                        gcnt_r <= gcnt_r + GW'(1);
                    end
                end
                ST_WAIT_RES: begin
                    if (res_valid_s) begin
                        slot_r[rcnt_r] <= pin_uo;
                        ack_r          <= 1'b1;
                        state_r        <= ST_ACK;
                    end else if (expired_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_x_r     <= 16'h0000;
                        rsp_y_r     <= 16'h0000;
                        state_r     <= ST_RESP;
                    end
                end
                ST_ACK: begin
                    ack_r   <= 1'b0;
                    state_r <= ST_DROP;
                end
                ST_DROP: begin
                    // A byte held across the ack is ignored until res_valid falls.
                    if (!res_valid_s) begin
                        if (rcnt_r == RCNT_LAST) begin
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            rsp_x_r     <= {slot_r[1], slot_r[0]};
                            rsp_y_r     <= {slot_r[3], slot_r[2]};
                            state_r     <= ST_RESP;
                        end else begin
                            rcnt_r  <= rcnt_r + 2'd1;
                            state_r <= ST_WAIT_RES;
                        end
                    end else if (expired_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_x_r     <= 16'h0000;
                        rsp_y_r     <= 16'h0000;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    strobe_r    <= 1'b0;
                    ack_r       <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Pin word assembled from the strobe and ack flops; unused bits stay low.
    always_comb begin
        pin_uio_to_s                = 8'h00;
        pin_uio_to_s[WR_STROBE_BIT] = strobe_r;
        pin_uio_to_s[RD_ACK_BIT]    = ack_r;
    end

    assign req_ready  = req_ready_s;
    assign pin_ui     = pin_ui_r;
    assign pin_uio_to = pin_uio_to_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_x      = rsp_x_r;
    assign rsp_y      = rsp_y_r;
    assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_cordic_pin_host.sv
// Randomized bench for cordic_pin_host: a behavioural engine model answers the pin
// protocol and a client model checks each response against the bytes it supplied.
module tb_cordic_pin_host;

    localparam int TO  = 15;
    localparam int GAP = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_mode;
    logic [15:0] req_angle;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_x;
    logic [15:0] rsp_y;
    logic        rsp_err;
    logic [7:0]  pin_ui;
    logic [7:0]  pin_uio_to;
    logic [7:0]  pin_uo;
    logic [7:0]  pin_uio_from;
    logic        busy;
    logic        res_valid;
    logic [7:0]  junk;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign pin_uio_from = {junk[7:4], res_valid, busy, junk[1:0]};

    cordic_pin_host #(
        .TIMEOUT_CYCLES(TO),
        .STROBE_GAP    (GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_mode    (req_mode),
        .req_angle   (req_angle),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_x       (rsp_x),
        .rsp_y       (rsp_y),
        .rsp_err     (rsp_err),
        .pin_ui      (pin_ui),
        .pin_uio_to  (pin_uio_to),
        .pin_uo      (pin_uo),
        .pin_uio_from(pin_uio_from)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction. rdata holds the four result bytes, byte0 in [7:0].
    task automatic run_txn(input logic [1:0] m, input logic [15:0] a, input logic [31:0] rdata,
                           input int hold, input bit silent, input int bp, input bit rst_mid);
        logic [7:0] wr_q[$];
        int  gaps[$];
        int  low_run = 0, dbl = 0, ack_cnt = 0, ridx = 0, hold_left = 0;
        int  low_left, last_strobe = 0, cyc = 0, w = 0, viol = 0;
        bit  prev_strobe = 1'b0, acked = 1'b0, got_rsp = 1'b0, did_rst = 1'b0;
        logic [7:0] upper = 8'h00;
        logic [15:0] ex_x, ex_y, hx, hy;
        logic [7:0] exp_b [3];

        exp_b[0] = 8'h80 | {6'b0, m};
        exp_b[1] = a[7:0];
        exp_b[2] = a[15:8];
        low_left = $urandom_range(0, 3);

        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1;
        req_mode  = m;
        req_angle = a;
        @(negedge clk);
        req_valid = 1'b0;
        req_mode  = 2'($urandom);
        req_angle = 16'($urandom);
        check_eq("first_strobe", {31'b0, pin_uio_to[0]}, 32'd1);

        while (cyc < 400 && !got_rsp && !did_rst) begin
            junk  = 8'($urandom);
            upper = upper | {2'b00, pin_uio_to[7:2]};
            if (pin_uio_to[0]) begin
                if (prev_strobe) dbl++;
                else if (wr_q.size() > 0) gaps.push_back(low_run);
                wr_q.push_back(pin_ui);
                low_run     = 0;
                last_strobe = cyc;
            end else begin
                low_run++;
            end
            prev_strobe = pin_uio_to[0];
            if (pin_uio_to[1]) ack_cnt++;

            if (wr_q.size() == 3 && !silent && ridx < 4) begin
                if (res_valid) begin
                    if (pin_uio_to[1]) begin
                        acked     = 1'b1;
                        hold_left = hold;
                    end
                    if (acked) begin
                        if (hold_left == 0) begin
                            res_valid = 1'b0;
                            pin_uo    = 8'($urandom);
                            acked     = 1'b0;
                            ridx++;
                            low_left  = 2 + $urandom_range(0, 3);
                        end else begin
                            hold_left--;
                        end
                    end
                end else if (low_left > 0) begin
                    low_left--;
                    pin_uo = 8'($urandom);
                end else begin
                    res_valid = 1'b1;
                    pin_uo    = rdata[8*ridx +: 8];
                end
            end

            if (rst_mid && ridx == 1 && res_valid) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_pin_ui", {24'b0, pin_ui}, 32'd0);
                check_eq("rst_pin_uio", {24'b0, pin_uio_to}, 32'd0);
                check_eq("rst_rsp", {14'b0, rsp_valid, rsp_err, rsp_x}, 32'd0);
                check_eq("rst_rsp_y", {16'b0, rsp_y}, 32'd0);
                check_eq("rst_req_ready", {31'b0, req_ready}, 32'd1);
                res_valid = 1'b0;
                viol = 0;
                repeat (3) begin
                    @(negedge clk);
                    if (pin_uio_to != 8'h00) viol++;
                end
                check_eq("rst_quiet", viol, 0);
                rst_n   = 1'b1;
                did_rst = 1'b1;
            end else if (rsp_valid) begin
                got_rsp = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end

        if (did_rst) return;
        check_eq("rsp_seen", {31'b0, got_rsp}, 32'd1);
        if (!got_rsp) return;

        check_eq("wr_count", wr_q.size(), 3);
        for (int i = 0; i < 3 && i < wr_q.size(); i++)
            check_eq($sformatf("wr_byte%0d", i), {24'b0, wr_q[i]}, {24'b0, exp_b[i]});
        for (int i = 0; i < gaps.size(); i++)
            check_eq("gap_len", gaps[i], GAP);
        check_eq("strobe_width", dbl, 0);
        check_eq("uio_upper", {24'b0, upper}, 32'd0);

        ex_x = silent ? 16'h0000 : rdata[15:0];
        ex_y = silent ? 16'h0000 : rdata[31:16];
        check_eq("rsp_x", {16'b0, rsp_x}, {16'b0, ex_x});
        check_eq("rsp_y", {16'b0, rsp_y}, {16'b0, ex_y});
        check_eq("rsp_err", {31'b0, rsp_err}, {31'b0, silent});
        check_eq("ack_count", ack_cnt, silent ? 0 : 4);
        check_eq("busy_rsp_ready", {31'b0, req_ready}, 32'd0);
        if (silent) begin
            check_eq("to_latency_max", {31'b0, (cyc - last_strobe) <= TO + 2}, 32'd1);
            check_eq("to_latency_min", {31'b0, (cyc - last_strobe) >= TO}, 32'd1);
        end

        hx = rsp_x;
        hy = rsp_y;
        viol = 0;
        repeat (bp) begin
            @(negedge clk);
            junk = 8'($urandom);
            if (!rsp_valid || rsp_x !== hx || rsp_y !== hy || rsp_err !== silent || req_ready)
                viol++;
        end
        check_eq("bp_stable", viol, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_done", {31'b0, rsp_valid}, 32'd0);
        check_eq("ready_after", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int viol;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_mode  = 2'b00;
        req_angle = 16'h0000;
        rsp_ready = 1'b0;
        busy      = 1'b0;
        res_valid = 1'b0;
        pin_uo    = 8'h00;
        junk      = 8'h00;
        #1;
        check_eq("reset_pins", {16'b0, pin_uio_to, pin_ui}, 32'd0);
        check_eq("reset_rsp", {14'b0, rsp_valid, rsp_err, rsp_x}, 32'd0);
        check_eq("reset_rsp_y", {16'b0, rsp_y}, 32'd0);
        check_eq("reset_ready", {31'b0, req_ready}, 32'd1);
        busy = 1'b1;
        #1;
        check_eq("reset_busy", {31'b0, req_ready}, 32'd0);
        busy = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(2'd1, 16'h3243, 32'h78563412, 0, 1'b0, 0, 1'b0);
        run_txn(2'd2, 16'($urandom), $urandom, 3, 1'b0, 0, 1'b0);
        run_txn(2'd3, 16'($urandom), $urandom, 1, 1'b0, 10, 1'b0);
        run_txn(2'd0, 16'($urandom), $urandom, 0, 1'b1, 2, 1'b0);

        busy      = 1'b1;
        req_valid = 1'b1;
        viol      = 0;
        repeat (5) begin
            @(negedge clk);
            if (req_ready || pin_uio_to[0]) viol++;
        end
        check_eq("busy_block", viol, 0);
        req_valid = 1'b0;
        @(negedge clk);
        busy = 1'b0;
        #1;
        check_eq("busy_release", {31'b0, req_ready}, 32'd1);
        @(negedge clk);

        run_txn(2'd1, 16'($urandom), $urandom, 0, 1'b0, 0, 1'b1);
        @(negedge clk);
        run_txn(2'd2, 16'h1234, 32'hCAFEBABE, 0, 1'b0, 1, 1'b0);

        for (int t = 0; t < 8; t++)
            run_txn(2'($urandom), 16'($urandom), $urandom, $urandom_range(0, 3), 1'b0,
                    $urandom_range(0, 3), 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cordic_pin_host.md
# cordic_pin_host

Host-side sequencer for the CORDIC engine's byte-serial pin protocol. It takes one parallel request (mode, 16-bit angle), writes it to the engine as three strobed bytes, collects the four result bytes with a per-byte acknowledge, and returns the two 16-bit results as one parallel response. It is used in FPGA bring-up and as a reusable master in system-level benches; it sits between a parallel client and the engine's `ui_in`/`uio_in`/`uo_out`/`uio_out` pins, all on the same clock.

## Interface
- `TIMEOUT_CYCLES`, default 1023: maximum number of cycles to wait for each result byte before aborting.
- `STROBE_GAP`, default 1 (minimum 1): idle cycles with the strobe low between consecutive byte writes.

- `clk`  in  1  clock; every flop is rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_mode`  in  2  CORDIC mode.
- `req_angle`  in  16  operand.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  client takes the response.
- `rsp_x`  out  16  first result word.
- `rsp_y`  out  16  second result word.
- `rsp_err`  out  1  response terminated by timeout.
- `pin_ui`  out  8  drives the engine's `ui_in`; carries write data.
- `pin_uio_to`  out  8  drives the engine's `uio_in`:
  - [0] `wr_strobe`
  - [1] `rd_ack`
  - [7:2] always 0.
- `pin_uo`  in  8  the engine's `uo_out`; carries the result byte.
- `pin_uio_from`  in  8  the engine's `uio_out`:
  - [2] `busy`
  - [3] `res_valid`
  - other bits ignored.

## Operation
- **States:** IDLE, WRITE, GAP, WAIT_RES, ACK, DROP, RESP.
- **IDLE**
  - `req_ready = (state==IDLE) && !busy`, combinational.
  - On handshake: latch mode and angle, set `wcnt=0`, go to WRITE.
- **WRITE**
  - Drive `pin_ui` with byte[`wcnt`] and hold `wr_strobe=1` for exactly one cycle.
  - Byte order:
    - byte0 = {1'b1, 5'b0, mode}
    - byte1 = angle[7:0]
    - byte2 = angle[15:8]
  - If `wcnt==2`, go to WAIT_RES with `rcnt=0` and the timer cleared.
  - Otherwise go to GAP.
- **GAP**
  - Strobe low for `STROBE_GAP` cycles.
  - `pin_ui` holds the previous byte.
  - Then `wcnt++` and go to WRITE.
- **WAIT_RES**
  - When `res_valid==1`, capture `pin_uo` into slot[`rcnt`] and go to ACK.
  - Otherwise the timer increments.
  - When the timer reaches `TIMEOUT_CYCLES`, go to RESP with `err=1`, `rsp_x=rsp_y=0`.
- **ACK**
  - `rd_ack=1` for one cycle, then go to DROP.
- **DROP**
  - Wait for `res_valid==0`; the timer keeps running with the same timeout rule.
  - This prevents a byte that is held high across the ack from being captured twice.
  - Then, if `rcnt==3`, go to RESP with `err=0`; otherwise `rcnt++`, clear the timer, and go to WAIT_RES.
- **Slot mapping:**
  - `rsp_x = {slot1, slot0}`
  - `rsp_y = {slot3, slot2}`
- **RESP**
  - `rsp_valid=1`; `rsp_*` held stable until `rsp_valid && rsp_ready`, then go to IDLE.
- `busy` is ignored outside IDLE.

## Timing
- **Reset values:**
  - State is IDLE.
  - `pin_ui=0`, `pin_uio_to=0`, `rsp_valid=0`, `rsp_x=0`, `rsp_y=0`, `rsp_err=0`.
  - `req_ready` follows `busy`.
- Reset asserted mid-transaction aborts immediately; no strobe or ack is emitted after `rst_n` falls.
- `pin_ui` and `pin_uio_to` are registered; no combinational path from any input to the pins.
- **Write phase length:** 3 strobe cycles + 2×`STROBE_GAP`. The first strobe occurs the cycle after the request handshake.
- **Read phase:** per byte, capture (the edge where `res_valid` is seen) → ack (+1) → drop detect (≥+1). Minimum 3 cycles per byte.
- **Timeout:** response `rsp_valid` rises at most `TIMEOUT_CYCLES`+1 cycles after the last progress event.
- **Back-to-back:** the earliest next `req_ready` is the cycle after the response handshake.

## Structure
- Package `cordic_pin_pkg` holds:
  - state enum
  - pin bit indices (`WR_STROBE_BIT=0`, `RD_ACK_BIT=1`, `BUSY_BIT=2`, `RES_VALID_BIT=3`)
  - `CMD_START=8'h80`
  - `N_WR_BYTES=3`, `N_RD_BYTES=4`
- One sub-module is natural: `cordic_pin_timer`, a clearable saturating counter with a `expired` flag, parameterised by `TIMEOUT_CYCLES`.

## Test plan
- **Write sequence:** `mode=1`, `angle=16'h3243`, `STROBE_GAP=1` → strobed bytes 0x81, 0x43, 0x32; each strobe exactly 1 cycle wide, 1-cycle gaps.
- **Readback:** model returns 0x12, 0x34, 0x56, 0x78 → `rsp_x=16'h3412`, `rsp_y=16'h7856`, `rsp_err=0`, exactly 4 `rd_ack` pulses.
- **Held byte:** model holds `res_valid` high for 3 cycles after the ack → exactly one capture per byte, result unchanged.
- **Backpressure:** `rsp_ready` low for 10 cycles → `rsp_*` stable, `req_ready=0` throughout; on release, `req_ready=1` the next cycle.
- **Timeout:** `res_valid` never asserted, `TIMEOUT_CYCLES=15` → `rsp_valid` within 17 cycles of the last strobe, with `rsp_err=1`, `rsp_x=rsp_y=0`.
- **Busy and reset:**
  - `busy=1` in IDLE → `req_ready=0`, no strobe.
  - `rst_n` pulsed during the second read byte → all outputs at reset values, state IDLE; the next request completes normally.
